// File: rtl/tbird_lights_param.sv
// ---------------------------------------------------------------------------
// tbird_lights_param
//
// Thunderbird-style tail-light sequencer with a configurable number of lamps
// per side. It produces sequential left/right turn patterns, hazard flashing
// and a brake override. An internal prescaler sets the animation rate.
//
// Parameters
//   LAMPS  lamps per side (>= 1); bit 0 is the innermost lamp
//   DIV    clock cycles per animation step (>= 1); 1 = step every cycle
//
// Ports
//   clk     in   rising-edge clock
//   reset   in   synchronous, active-low reset
//   left    in   left-turn request (level)
//   right   in   right-turn request (level)
//   hazard  in   hazard request (level)
//   brake   in   brake pedal (level); reaches the lamps combinationally
//   lamp_l  out  left lamps, bit 0 innermost
//   lamp_r  out  right lamps, bit 0 innermost
//   busy    out  high whenever the sequencer is not idle
// ---------------------------------------------------------------------------
module tbird_lights_param #(
  parameter int LAMPS = 3,
  parameter int DIV   = 1
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             left,
  input  logic             right,
  input  logic             hazard,
  input  logic             brake,
  output logic [LAMPS-1:0] lamp_l,
  output logic [LAMPS-1:0] lamp_r,
  output logic             busy
);

  localparam int KW = $clog2(LAMPS + 1);
  localparam int PW = (DIV > 1) ? $clog2(DIV) : 1;

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LEFT  = 2'd1,
    RIGHT = 2'd2,
    HAZ   = 2'd3
  } state_t;

  state_t          state_r, state_n_s;
  logic [KW-1:0]   k_r, k_n_s;
  logic            phase_r, phase_n_s;
  logic [PW-1:0]   pre_r;
  logic            step_s;
  logic            haz_req_s;

  // Lowest k bits set: the turn pattern shown at step k of a sequence.
  function automatic logic [LAMPS-1:0] pattern(input logic [KW-1:0] k);
    logic [LAMPS-1:0] p;
    p = '0;
    for (int i = 0; i < LAMPS; i++) begin
      p[i] = (KW'(i) < k);
    end
    return p;
  endfunction

  assign step_s    = (pre_r == PW'(DIV - 1));
  // Both turn requests at once are treated exactly like a hazard request.
  assign haz_req_s = hazard | (left & right);

  // Prescaler: counts 0..DIV-1 and wraps; the wrap cycle is the step cycle.
  always_ff @(posedge clk) begin
    if (!reset) begin
      pre_r <= '0;
    end else if (step_s) begin
      pre_r <= '0;
    end else begin
      pre_r <= pre_r + PW'(1);
    end
  end

  // State, step counter and hazard phase registers.
  always_ff @(posedge clk) begin
    if (!reset) begin
      state_r <= IDLE;
      k_r     <= '0;
      phase_r <= 1'b0;
    end else begin
      state_r <= state_n_s;
      k_r     <= k_n_s;
      phase_r <= phase_n_s;
    end
  end

  // Next-state logic; inputs only matter on step cycles.
  always_comb begin
    state_n_s = state_r;
    k_n_s     = k_r;
    phase_n_s = phase_r;
    if (step_s) begin
      case (state_r)
        IDLE: begin
          if (haz_req_s) begin
            state_n_s = HAZ;
            phase_n_s = 1'b1;
          end else if (left) begin
            state_n_s = LEFT;
            k_n_s     = KW'(1);
          end else if (right) begin
            state_n_s = RIGHT;
            k_n_s     = KW'(1);
          end else begin
            state_n_s = IDLE;
          end
        end
        LEFT, RIGHT: begin
          // A running sequence ignores release and the opposite side;
          // only a hazard aborts it.
          if (haz_req_s) begin
            state_n_s = HAZ;
            phase_n_s = 1'b1;
            k_n_s     = '0;
          end else if (k_r < KW'(LAMPS)) begin
            k_n_s = k_r + KW'(1);
          end else begin
            state_n_s = IDLE;
            k_n_s     = '0;
          end
        end
        HAZ: begin
          if (haz_req_s) begin
            phase_n_s = ~phase_r;
          end else begin
            state_n_s = IDLE;
            phase_n_s = 1'b0;
          end
        end
        default: begin
          state_n_s = IDLE;
          k_n_s     = '0;
          phase_n_s = 1'b0;
        end
      endcase
    end else begin
      state_n_s = state_r;
    end
  end

  // Lamp decode from state; brake overrides the non-animated side(s)
  // without a register, but never touches the hazard flash.
  always_comb begin
    lamp_l = '0;
    lamp_r = '0;
    case (state_r)
      IDLE: begin
        lamp_l = brake ? '1 : '0;
        lamp_r = brake ? '1 : '0;
      end
      LEFT: begin
        lamp_l = pattern(k_r);
        lamp_r = brake ? '1 : '0;
      end
      RIGHT: begin
        lamp_l = brake ? '1 : '0;
        lamp_r = pattern(k_r);
      end
      HAZ: begin
        lamp_l = phase_r ? '1 : '0;
        lamp_r = phase_r ? '1 : '0;
      end
      default: begin
        lamp_l = '0;
        lamp_r = '0;
      end
    endcase
  end

  assign busy = (state_r != IDLE);

endmodule

// File: doc/tbird_lights_param.md
# tbird_lights_param

Parametrised Thunderbird-style tail-light sequencer: drives a configurable number of lamps per side, producing sequential left/right turn patterns, hazard flashing and brake override. An internal prescaler sets the animation rate. It is the next generation of the lab-2 three-lamp turn-signal FSM and sits between the driver-input synchroniser and the lamp drivers.

## Interface
- LAMPS, 3: lamps per side, ≥1; bit 0 is the innermost lamp.
- DIV, 1: clock cycles per animation step, ≥1; DIV=1 steps every cycle.
- clk  in  1  clock; all state changes on rising edge.
- reset  in  1  synchronous, active-low.
- left  in  1  left-turn request, level.
- right  in  1  right-turn request, level.
- hazard  in  1  hazard request, level.
- brake  in  1  brake pedal, level; combinational effect on outputs.
- lamp_l  out  LAMPS  left lamps, bit 0 innermost.
- lamp_r  out  LAMPS  right lamps, bit 0 innermost.
- busy  out  1  high whenever state ≠ IDLE.

## Operation
- States: IDLE, LEFT, RIGHT, HAZ. A step counter k (0..LAMPS, width $clog2(LAMPS+1)) is used in LEFT/RIGHT; a phase bit is used in HAZ.
- Prescaler: counter 0..DIV-1 (width max(1,$clog2(DIV))), wraps to 0; `step` = (counter == DIV-1). State, k and phase change only on cycles where `step` is high; inputs are sampled only on those cycles.
- IDLE on step: hazard or (left & right) → HAZ, phase=1; else left → LEFT, k=1; else right → RIGHT, k=1; else stay.
- LEFT/RIGHT on step: hazard or (left & right) → HAZ, phase=1 (aborts the sequence); else if k < LAMPS → k+1; else (k == LAMPS) → IDLE, k=0. A started sequence runs to completion even if the request is released. A request for the opposite side is ignored until IDLE.
- HAZ on step: hazard or (left & right) → phase toggles; else → IDLE, phase=0.
- Pattern P(k) = lowest k bits set (k=0 → all zero, k=LAMPS → all ones).
- Outputs (Moore, plus brake):
  - IDLE: lamp_l = lamp_r = brake ? all-ones : 0.
  - LEFT: lamp_l = P(k); lamp_r = brake ? all-ones : 0.
  - RIGHT: mirror of LEFT.
  - HAZ: both sides = phase ? all-ones : 0; brake ignored.
- IDLE for one step between consecutive turn sequences gives the all-off frame: with left held, the pattern period is LAMPS+1 steps.

## Timing
- Reset (reset=0 at a rising edge): state IDLE, k=0, phase=0, prescaler=0, busy=0. With brake=0, lamp_l = lamp_r = 0 from the cycle after that edge. Reset overrides everything, including mid-sequence and mid-hazard.
- First step after reset release occurs DIV cycles after the release edge. With DIV=1, a request high at edge n gives its first pattern visible after edge n.
- Each non-IDLE pattern is held exactly DIV cycles. A request shorter than DIV cycles that misses the step cycle is not seen.
- brake reaches the outputs in the same cycle, with no register.
- Simultaneous left & right is treated as hazard everywhere; hazard has priority over left and right.
- LAMPS=1: LEFT shows 1 for one step, then IDLE.

## Test plan
- LAMPS=3, DIV=1, left held from reset release: lamp_l per cycle = 001,011,111,000,001…; lamp_r = 000; busy = 1,1,1,0,1.
- Left pulsed for a single step cycle: lamp_l = 001,011,111, then 000 and stays IDLE; a right request during the sequence is ignored until IDLE.
- hazard=1 (or left=right=1): both sides alternate 111/000 each step starting 111; a hazard raised at LEFT k=2 aborts to 111/111 at the next step; release → 000, IDLE.
- brake=1 during LEFT: lamp_r = 111 in the same cycle while lamp_l continues its sequence; brake in IDLE → both 111; brake during HAZ → no effect.
- DIV=4, left held: each of 001,011,111,000 is held exactly 4 cycles; first change is 4 cycles after reset release.
- Reset asserted at LEFT k=2 and at HAZ phase=1: outputs are 000/000 and busy=0 the next cycle; LAMPS=1 and LAMPS=5 variants give the correct period (2 and 6 steps).
